// File: rtl/unsat_sel_pkg.sv
// Shared encodings for the unsat-clause selector sequencer: datapath stage codes,
// sequencer states and the optional LFSR constants.
package unsat_sel_pkg;

  localparam logic [1:0] STG_LATCH = 2'b00;
  localparam logic [1:0] STG_MUL   = 2'b01;
  localparam logic [1:0] STG_MOD   = 2'b10;
  localparam logic [1:0] STG_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    LOAD, IDLE, LATCH, MUL, MOD, CAPT, RESP
  } state_t;

  // Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/unsat_sel_lfsr.sv
// 32-bit Galois LFSR free-running random source; used only when UNSAT_SEL_LFSR_EN is defined.
module unsat_sel_lfsr
  import unsat_sel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] o_lfsr
);

  always_ff @(posedge clk) begin
    if (reset) o_lfsr <= LFSR_SEED;
    else       o_lfsr <= (o_lfsr >> 1) ^ (o_lfsr[0] ? LFSR_TAPS : 32'h0);
  end

endmodule

// File: rtl/unsat_select_ctrl.sv
// Sequencer for the unsat-clause index selector: loads the 1/(i+1) table, then walks the
// datapath LATCH->MUL->MOD per request. Optional internal LFSR via UNSAT_SEL_LFSR_EN.
module unsat_select_ctrl
  import unsat_sel_pkg::*;
#(
  parameter  int BUFFER_DEPTH  = 2048,
  parameter  int M_TABLE_WIDTH = 32,
  parameter  int RANDOM_WIDTH  = 32,
  localparam int AW            = $clog2(BUFFER_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid_i,
  input  logic [AW-1:0]            ld_addr_i,
  input  logic [M_TABLE_WIDTH-1:0] ld_data_i,
  input  logic                     ld_last_i,
  output logic                     ld_ready_o,
  input  logic                     req_valid_i,
  input  logic [AW-1:0]            req_count_i,
  output logic                     req_ready_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [AW-1:0]            rsp_index_o,
  output logic                     rsp_empty_o,
`ifndef UNSAT_SEL_LFSR_EN
  input  logic [RANDOM_WIDTH-1:0]  random_i,
`endif
  output logic                     dp_setup_o,
  output logic                     dp_we_o,
  output logic [AW-1:0]            dp_wr_addr_o,
  output logic [M_TABLE_WIDTH-1:0] dp_m_data_o,
  output logic [1:0]               dp_stage_o,
  output logic [AW-1:0]            dp_count_o,
  output logic [RANDOM_WIDTH-1:0]  dp_random_o,
  input  logic [AW-1:0]            dp_selected_i
);

  state_t                  r_state;
  logic [RANDOM_WIDTH-1:0] w_rand;

`ifdef UNSAT_SEL_LFSR_EN
  logic [31:0] w_lfsr;
  unsat_sel_lfsr u_lfsr (.clk(clk), .reset(reset), .o_lfsr(w_lfsr));
  assign w_rand = RANDOM_WIDTH'(w_lfsr);
`else
  assign w_rand = random_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LOAD;
      ld_ready_o   <= 1'b1;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_index_o  <= '0;
      rsp_empty_o  <= 1'b0;
      dp_setup_o   <= 1'b1;
      dp_we_o      <= 1'b0;
      dp_wr_addr_o <= '0;
      dp_m_data_o  <= '0;
      dp_stage_o   <= STG_IDLE;
      dp_count_o   <= '0;
      dp_random_o  <= '0;
    end else begin
      dp_we_o <= 1'b0;
      case (r_state)
        LOAD: begin
          if (ld_valid_i && ld_ready_o) begin
            dp_we_o      <= 1'b1;
            dp_wr_addr_o <= ld_addr_i;
            dp_m_data_o  <= ld_data_i;
            if (ld_last_i) begin
              r_state     <= IDLE;
              ld_ready_o  <= 1'b0;
              req_ready_o <= 1'b1;
            end
          end
        end
        IDLE: begin
          // setup stays high one extra cycle so the final table write lands
          dp_setup_o <= 1'b0;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            dp_count_o  <= req_count_i;
            dp_random_o <= w_rand;
            if (req_count_i == '0) begin
              rsp_valid_o <= 1'b1;
              rsp_empty_o <= 1'b1;
              rsp_index_o <= '0;
              r_state     <= RESP;
            end else begin
              rsp_empty_o <= 1'b0;
              dp_stage_o  <= STG_LATCH;
              r_state     <= LATCH;
            end
          end
        end
        LATCH: begin
          dp_stage_o <= STG_MUL;
          r_state    <= MUL;
        end
        MUL: begin
          dp_stage_o <= STG_MOD;
          r_state    <= MOD;
        end
        MOD: begin
          dp_stage_o  <= STG_IDLE;
          rsp_index_o <= dp_selected_i;
          r_state     <= CAPT;
        end
        CAPT: begin
          rsp_valid_o <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
